// File: rtl/aucohl_uart_rx_if.sv
// ---------------------------------------------------------------------------
// aucohl_uart_rx_if
// Receive-side bundle between the UART receiver and the receive FIFO.
//   wr          : one-cycle write strobe, wdata valid
//   wdata       : received word, LSB = first data bit on the line
//   full        : FIFO full, sampled by the receiver when a frame completes
//   parity_err  : one-cycle pulse coincident with wr
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, completed frame dropped because full
// master = receiver (drives strobe/data/errors), slave = FIFO (drives full).
// ---------------------------------------------------------------------------
interface aucohl_uart_rx_if #(
    parameter int DW = 8
);
    logic          wr;
    logic [DW-1:0] wdata;
    logic          full;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;

    modport master (
        output wr, wdata, parity_err, frame_err, overrun_err,
        input  full
    );

    modport slave (
        input  wr, wdata, parity_err, frame_err, overrun_err,
        output full
    );
endinterface

// File: rtl/aucohl_uart_rx.sv
// ---------------------------------------------------------------------------
// aucohl_uart_rx
// 16x oversampling asynchronous serial receiver (8N1 / 8E1 / 8O1 style).
// Good frames are delivered as a single-cycle write strobe into a FIFO.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   en         : receiver enable, low forces idle and discards any frame
//   rx         : raw serial line (idle high), asynchronous to clk
//   prescale   : tick divider, tick period = prescale+1 clocks
//   parity_en  : parity bit follows the data bits
//   parity_odd : 1 = odd parity, 0 = even parity
//   fifo       : master side of aucohl_uart_rx_if (wr/wdata/errors, full)
//
// prescale, parity_en and parity_odd are expected to change only while idle.
// ---------------------------------------------------------------------------
module aucohl_uart_rx #(
    parameter int DW = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          rx,
    input  logic [PW-1:0] prescale,
    input  logic          parity_en,
    input  logic          parity_odd,
    aucohl_uart_rx_if.master fifo
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam logic [3:0] SC_MID_START = 4'd7;
    localparam logic [3:0] SC_LAST      = 4'd15;
    localparam logic [3:0] BC_LAST      = 4'(DW - 1);

    // Input synchronizer; resets to the idle line level so reset never
    // looks like a start edge.
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];

    // Oversample tick: fires when the down-counter reaches zero, then the
    // counter reloads. Held at zero while disabled so the first enabled
    // clock produces a tick immediately.
    logic [PW-1:0] cnt_reg;
    logic          tick;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg == '0) begin
            cnt_reg <= prescale;
        end else begin
            cnt_reg <= cnt_reg - PW'(1);
        end
    end

    assign tick = en && (cnt_reg == '0);

    // Frame state
    logic [2:0]    state_reg,   state_next;
    logic [3:0]    sc_reg,      sc_next;
    logic [3:0]    bc_reg,      bc_next;
    logic [DW-1:0] shreg_reg,   shreg_next;
    logic          pflag_reg,   pflag_next;
    logic [DW-1:0] wdata_reg,   wdata_next;
    logic          wr_reg,      wr_next;
    logic          perr_reg,    perr_next;
    logic          ferr_reg,    ferr_next;
    logic          ovr_reg,     ovr_next;

    always_comb begin
        state_next = state_reg;
        sc_next    = sc_reg;
        bc_next    = bc_reg;
        shreg_next = shreg_reg;
        pflag_next = pflag_reg;
        wdata_next = wdata_reg;
        // Status outputs are strobes: low unless set below.
        wr_next    = 1'b0;
        perr_next  = 1'b0;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;

        if (!en) begin
            state_next = ST_IDLE;
            sc_next    = '0;
            bc_next    = '0;
        end else if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next = ST_START;
                        sc_next    = '0;
                    end
                end

                ST_START: begin
                    if (sc_reg == SC_MID_START) begin
                        // Re-check the line at mid start bit to reject glitches.
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            sc_next    = '0;
                            bc_next    = '0;
                            pflag_next = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            sc_next    = '0;
                        end
                    end else begin
                        sc_next = sc_reg + 4'd1;
                    end
                end

                ST_DATA: begin
                    // sc wraps 15 -> 0, so each later sample lands one full
                    // bit time after the previous one.
                    sc_next = sc_reg + 4'd1;
                    if (sc_reg == SC_LAST) begin
                        shreg_next = {rx_s, shreg_reg[DW-1:1]};
                        bc_next    = bc_reg + 4'd1;
                        if (bc_reg == BC_LAST) begin
                            state_next = parity_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end

                ST_PARITY: begin
                    sc_next = sc_reg + 4'd1;
                    if (sc_reg == SC_LAST) begin
                        pflag_next = (^shreg_reg) ^ rx_s ^ parity_odd;
                        state_next = ST_STOP;
                    end
                end

                ST_STOP: begin
                    sc_next = sc_reg + 4'd1;
                    if (sc_reg == SC_LAST) begin
                        if (rx_s) begin
                            state_next = ST_IDLE;
                            if (!fifo.full) begin
                                wr_next    = 1'b1;
                                wdata_next = shreg_reg;
                                perr_next  = pflag_reg;
                            end else begin
                                ovr_next = 1'b1;
                            end
                        end else begin
                            // Data is discarded on a framing error; wait for
                            // the line to recover before hunting for a start.
                            ferr_next  = 1'b1;
                            state_next = ST_BREAK;
                        end
                    end
                end

                ST_BREAK: begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                        sc_next    = '0;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    sc_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sc_reg    <= '0;
            bc_reg    <= '0;
            shreg_reg <= '0;
            pflag_reg <= 1'b0;
            wdata_reg <= '0;
            wr_reg    <= 1'b0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sc_reg    <= sc_next;
            bc_reg    <= bc_next;
            shreg_reg <= shreg_next;
            pflag_reg <= pflag_next;
            wdata_reg <= wdata_next;
            wr_reg    <= wr_next;
            perr_reg  <= perr_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign fifo.wr          = wr_reg;
    assign fifo.wdata       = wdata_reg;
    assign fifo.parity_err  = perr_reg;
    assign fifo.frame_err   = ferr_reg;
    assign fifo.overrun_err = ovr_reg;

endmodule

// File: doc/aucohl_uart_rx.md
# aucohl_uart_rx

Asynchronous serial receiver: oversamples a raw `rx` line at 16x the bit rate and recovers 8N1/8E1/8O1-style frames. Each good frame is delivered as a single-cycle write strobe plus data word, intended to drive the `wr`/`wdata`/`full` side of the library FIFO directly. The block sits between the pad and the receive FIFO and contains its own input synchronizer and baud tick generator.

## Interface
- `DW`, 8: data bits per frame (5..9).
- `PW`, 16: prescaler width.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  receiver enable; low forces idle.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `prescale`  in  PW  oversample tick divider; tick period = `prescale`+1 clocks.
- `parity_en`  in  1  parity bit present after data.
- `parity_odd`  in  1  1 = odd parity, 0 = even.
- `full`  in  1  downstream FIFO full.
- `wr`  out  1  one-cycle write strobe, data valid.
- `wdata`  out  DW  received word, LSB = first data bit.
- `parity_err`  out  1  one-cycle pulse, coincident with `wr`.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse, frame dropped because `full`.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1); all logic uses synchronized `rx_s`.
- Tick generator: counter loads `prescale` and decrements; tick when counter = 0, then reload. `prescale`=0 ⇒ tick every clock. Counter held at 0 while `en`=0. Bit time = 16 ticks.
- Sub-bit counter `sc` (4 bits) counts ticks in frame states; bit counter `bc` counts data bits.
- States:
  - IDLE: on tick with `rx_s`=0 → START, `sc`=0.
  - START: at `sc`=7 (mid start bit) sample; `rx_s`=0 → DATA, `sc`=0, `bc`=0; `rx_s`=1 → IDLE (false start, no outputs).
  - DATA: at `sc`=15 sample `rx_s` into shift register (LSB first), `bc`++; after `DW` bits → PARITY if `parity_en`, else STOP.
  - PARITY: at `sc`=15 sample; error if XOR(data, sampled bit, `parity_odd`) ≠ 0 → STOP.
  - STOP: at `sc`=15 sample. 1 → deliver, IDLE. 0 → `frame_err`, BREAK.
  - BREAK: wait for tick with `rx_s`=1 → IDLE.
- Deliver: if `full`=0, `wr`=1 with `wdata` and `parity_err` (if flagged); if `full`=1, no `wr`, `overrun_err`=1 instead, `parity_err` suppressed.
- Frame error discards data: no `wr`, no `parity_err`.
- `wdata` holds last delivered word until next `wr`.
- `en` deasserted mid-frame: next clock → IDLE, frame discarded, no pulses.
- `parity_en`, `parity_odd`, `prescale` must be static during a frame; change only in IDLE.

## Timing
- Reset: all outputs 0, `wdata`=0, state IDLE, synchronizer flops 1, counters 0. `rst` mid-frame aborts it with no pulses.
- Input latency 2 clocks (synchronizer); start detection resolution 1 tick.
- Samples at mid-bit: start at tick 8 after detection, data bit k at tick 8+16(k+1).
- `wr`/error outputs are registered: assert the clock after the stop-bit sample tick, high exactly 1 clock.
- `full` is evaluated in the stop-sample clock.
- Back-to-back frames supported: new start detectable on first tick after return to IDLE.

## Test plan
- `prescale`=0, no parity, send 0xA5 (16-clk bits) → one `wr` with `wdata`=0xA5, no error pulses, `wr` ≈ 154 clocks after start edge.
- `rx` low for 4 ticks then high → no `wr`, no errors, state back to IDLE; subsequent 0x3C frame received correctly.
- `parity_en`=1, `parity_odd`=0, send 0x03 with parity bit 1 → `wr` with 0x03 and `parity_err`=1 same cycle; repeat with parity bit 0 → no `parity_err`.
- Stop bit 0 then `rx` held low 40 bit-times → single `frame_err`, no `wr`; after `rx` returns high, 0x55 received normally.
- `full`=1 during stop sample of 0x81 → `overrun_err` 1 cycle, no `wr`, `wdata` unchanged; `prescale`=2, back-to-back 0x00,0xFF → two `wr`s, 48-clk bits.
- `rst` pulsed during data bit 3 → all outputs 0 immediately after, no pulses; next frame 0x96 received correctly.
